// File: rtl/ssr_interrog_seq.sv
// SSR interrogation sequencer: builds the P1/P2/P3 pulse train for one mode
// per trigger, round-robins through the enabled modes, then fires the STC
// start and holds a bounded listen window for the receiver path.
module ssr_interrog_seq #(
    parameter int CNT_W      = 12,
    parameter int P_W        = 14,
    parameter int P2_OFS     = 40,
    parameter int P2_W       = 16,
    parameter int SP0        = 60,
    parameter int SP1        = 100,
    parameter int SP2        = 160,
    parameter int SP3        = 420,
    parameter int STC_DLY    = 46,
    parameter int LISTEN_MAX = 4000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       trig,
    input  logic [3:0] mode_mask,
    input  logic       p2_en,
    input  logic       oddeven,
    input  logic       stop,
    input  logic       abort,
    output logic       p_out,
    output logic       mo,
    output logic [1:0] mode_sel,
    output logic       busy,
    output logic       start_shift,
    output logic       start_stc,
    output logic       rx_sync,
    output logic       done,
    output logic       timeout,
    output logic       trig_ovr
);

    typedef enum logic [1:0] {IDLE, XMIT, LISTEN} state_t;

    localparam logic [CNT_W-1:0] C_PW    = CNT_W'(P_W);
    localparam logic [CNT_W-1:0] C_P2O   = CNT_W'(P2_OFS);
    localparam logic [CNT_W-1:0] C_P2E   = CNT_W'(P2_OFS + P2_W);
    localparam logic [CNT_W-1:0] C_STC   = CNT_W'(STC_DLY);
    localparam logic [CNT_W-1:0] C_LLAST = CNT_W'(LISTEN_MAX - 1);

    function automatic logic [CNT_W-1:0] sp_of(input logic [1:0] m);
        case (m)
            2'd0:    sp_of = CNT_W'(SP0);
            2'd1:    sp_of = CNT_W'(SP1);
            2'd2:    sp_of = CNT_W'(SP2);
            default: sp_of = CNT_W'(SP3);
        endcase
    endfunction

    state_t           state_reg, state_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic [1:0]       rr_reg, rr_next;
    logic [1:0]       mode_reg, mode_next;
    logic             p2_reg, p2_next;

    logic p_out_reg, mo_reg, busy_reg, start_shift_reg, start_stc_reg;
    logic rx_sync_reg, done_reg, timeout_reg, trig_ovr_reg;
    logic p_out_next, mo_next, busy_next, start_shift_next, start_stc_next;
    logic rx_sync_next, done_next, timeout_next, trig_ovr_next;

    // Round-robin candidates: the four modes in order starting just after rr_reg.
    logic [1:0] cand [4];
    logic [3:0] hit;
    logic [1:0] pick;

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_cand
            assign cand[gi] = rr_reg + 2'(gi + 1);
            assign hit[gi]  = mode_mask[cand[gi]];
        end
    endgenerate

    // Nearest enabled candidate wins.
    always_comb begin
        pick = cand[0];
        for (int i = 3; i >= 0; i--) begin
            if (hit[i]) pick = cand[i];
        end
    end

    logic [CNT_W-1:0] stc_t_cur;
    assign stc_t_cur = sp_of(mode_reg) + C_PW + C_STC;

    // Next-state, counter and latched-mode logic; abort overrides stop/expiry.
    always_comb begin
        state_next   = state_reg;
        cnt_next     = cnt_reg;
        rr_next      = rr_reg;
        mode_next    = mode_reg;
        p2_next      = p2_reg;
        done_next    = 1'b0;
        timeout_next = 1'b0;
        case (state_reg)
            IDLE: begin
                cnt_next = '0;
                if (trig && (mode_mask != 4'b0000)) begin
                    state_next = XMIT;
                    rr_next    = pick;
                    mode_next  = pick;
                    p2_next    = p2_en;
                end
            end
            XMIT: begin
                if (abort) begin
                    state_next = IDLE;
                    cnt_next   = '0;
                end else if (cnt_reg == stc_t_cur) begin
                    state_next = LISTEN;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end
            LISTEN: begin
                if (abort) begin
                    state_next = IDLE;
                    cnt_next   = '0;
                end else if (stop || (cnt_reg == C_LLAST)) begin
                    state_next   = IDLE;
                    cnt_next     = '0;
                    done_next    = 1'b1;
                    timeout_next = !stop;
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end
            default: begin
                state_next = IDLE;
                cnt_next   = '0;
            end
        endcase
    end

    // Outputs are decoded from the next state/counter so the registered
    // versions line up with the cycle that state is current.
    logic [CNT_W-1:0] sp_n;
    logic             in_xmit, mo_win;
    always_comb begin
        sp_n             = sp_of(mode_next);
        in_xmit          = (state_next == XMIT);
        mo_win           = (cnt_next >= C_P2O) && (cnt_next < C_P2E);
        p_out_next       = in_xmit && ((cnt_next < C_PW) || (p2_next && mo_win) ||
                           ((cnt_next >= sp_n) && (cnt_next < sp_n + C_PW)));
        mo_next          = in_xmit && mo_win;
        start_shift_next = in_xmit && (state_reg == IDLE);
        start_stc_next   = in_xmit && (cnt_next == sp_n + C_PW + C_STC);
        rx_sync_next     = (state_next == LISTEN) && oddeven;
        busy_next        = (state_next != IDLE);
        trig_ovr_next    = trig && (state_reg != IDLE);
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_reg       <= IDLE;
            cnt_reg         <= '0;
            rr_reg          <= 2'd3;
            mode_reg        <= 2'd0;
            p2_reg          <= 1'b0;
            p_out_reg       <= 1'b0;
            mo_reg          <= 1'b0;
            busy_reg        <= 1'b0;
            start_shift_reg <= 1'b0;
            start_stc_reg   <= 1'b0;
            rx_sync_reg     <= 1'b0;
            done_reg        <= 1'b0;
            timeout_reg     <= 1'b0;
            trig_ovr_reg    <= 1'b0;
        end else begin
            state_reg       <= state_next;
            cnt_reg         <= cnt_next;
            rr_reg          <= rr_next;
            mode_reg        <= mode_next;
            p2_reg          <= p2_next;
            p_out_reg       <= p_out_next;
            mo_reg          <= mo_next;
            busy_reg        <= busy_next;
            start_shift_reg <= start_shift_next;
            start_stc_reg   <= start_stc_next;
            rx_sync_reg     <= rx_sync_next;
            done_reg        <= done_next;
            timeout_reg     <= timeout_next;
            trig_ovr_reg    <= trig_ovr_next;
        end
    end

    assign p_out       = p_out_reg;
    assign mo          = mo_reg;
    assign mode_sel    = mode_reg;
    assign busy        = busy_reg;
    assign start_shift = start_shift_reg;
    assign start_stc   = start_stc_reg;
    assign rx_sync     = rx_sync_reg;
    assign done        = done_reg;
    assign timeout     = timeout_reg;
    assign trig_ovr    = trig_ovr_reg;

endmodule

// File: doc/ssr_interrog_seq.md
Name: ssr_interrog_seq

Overview:
- Parametrised SSR interrogation sequencer. Generates P1/P2/P3 pulse trains with per-mode P1→P3 spacing (Mode 1/2/3A/C), an optional P2 (SLS) pulse and a P2 control window (mo).
- Interleaves enabled modes round-robin across successive triggers.
- After P3, issues STC start and opens a bounded listen window for the receiver path.
- Sits between the PRF/trigger generator and the modulator / STC / range-counter logic.

Parameters:
- CNT_W, 12, width of the tick counter (1 tick = 0.05 us at 20 MHz).
- P_W, 14, P1 and P3 width in ticks (0.7 us).
- P2_OFS, 40, P1-rise to P2-rise offset in ticks (2.0 us).
- P2_W, 16, P2 / mo width in ticks (0.8 us).
- SP0, 60, Mode 1 P1-rise to P3-rise in ticks (3 us).
- SP1, 100, Mode 2 spacing (5 us).
- SP2, 160, Mode 3/A spacing (8 us).
- SP3, 420, Mode C spacing (21 us).
- STC_DLY, 46, ticks from P3 fall to start_stc.
- LISTEN_MAX, 4000, listen window length in ticks (200 us).
- Legal configuration: P2_OFS+P2_W <= min(SPn); all values < 2^CNT_W.

Ports:
- clk  in  1  system clock, 20 MHz.
- rst  in  1  synchronous active-low reset.
- trig  in  1  start request, sampled in IDLE.
- mode_mask  in  4  enabled modes; bit n = mode n (spacing SPn).
- p2_en  in  1  1 = transmit P2; 0 = P2 suppressed, mo still generated.
- oddeven  in  1  gates rx_sync during listen.
- stop  in  1  end listen early.
- abort  in  1  kill sequence immediately.
- p_out  out  1  P1/P2/P3 pulse train.
- mo  out  1  P2 window.
- mode_sel  out  2  mode of current/last sequence.
- busy  out  1  high outside IDLE.
- start_shift  out  1  one-cycle pulse, first P1 cycle.
- start_stc  out  1  one-cycle STC/range start.
- rx_sync  out  1  listen && oddeven.
- done  out  1  one-cycle pulse on normal completion.
- timeout  out  1  one-cycle pulse when listen expired without stop.
- trig_ovr  out  1  one-cycle pulse for a trigger dropped while busy.

Behaviour:
- Clock and reset: single clock clk; reset rst is synchronous and active-low.
- All outputs are registered. On reset all outputs are 0, state = IDLE, counter = 0, rr_ptr = 3 (so the first selected mode is 0).
- States: IDLE, XMIT, LISTEN.
- IDLE, trig=1, mode_mask≠0 (cycle k):
  - Select the first set bit of mode_mask strictly after rr_ptr, wrapping 3→0.
  - Latch the selected mode into mode_sel and rr_ptr; latch p2_en.
  - Enter XMIT with t=0 at cycle k+1.
- IDLE, trig=1, mode_mask=0: ignored, no output activity.
- XMIT: t increments by 1 each cycle.
  - p_out=1 for t in [0, P_W-1].
  - p_out=1 for t in [P2_OFS, P2_OFS+P2_W-1] when latched p2_en=1.
  - p_out=1 for t in [SPsel, SPsel+P_W-1].
  - mo=1 for t in [P2_OFS, P2_OFS+P2_W-1], independent of p2_en.
  - start_shift=1 at t=0.
  - start_stc=1 at t = SPsel+P_W+STC_DLY; the next cycle enters LISTEN with the counter at l=0.
- LISTEN: rx_sync = oddeven (registered). Counter l increments.
  - stop=1 → next cycle IDLE, done=1.
  - Otherwise at l=LISTEN_MAX-1 → next cycle IDLE, done=1 and timeout=1.
  - stop in the same cycle as expiry counts as stop: timeout=0.
- stop outside LISTEN is ignored.
- trig while busy: ignored, trig_ovr pulses the next cycle; the running sequence is unaffected.
- abort in XMIT or LISTEN: the next cycle is IDLE with all pulse outputs 0. done and timeout are not asserted. rr_ptr keeps its advanced value. abort has priority over stop and expiry. abort in IDLE has no effect.
- Inputs change during a sequence: mode_mask and p2_en changes take effect only at the next accepted trigger.
- trig on the cycle done is asserted (state already IDLE): accepted normally.
- Counter never wraps in a legal configuration. Each comparison uses CNT_W-bit unsigned equality.

Test Plan:
- Mode 0 normal run: mask=0001, p2_en=1, trig at k, stop held low.
  - p_out high k+1..k+14, k+41..k+56, k+61..k+74; mo high k+41..k+56.
  - start_shift at k+1; start_stc at k+121.
  - done and timeout at k+4122.
- Mode C, P2 suppressed: mask=1000, p2_en=0.
  - No p_out in k+41..k+56 while mo is still high there.
  - P3 at k+421..k+434; start_stc at k+481.
- Round-robin: mask=1011, four triggers each completed by stop → mode_sel 0,1,3,0.
  - Change mask to 0100 mid-sequence → next mode_sel=2.
- Early stop and rx_sync: oddeven=1, stop pulsed 10 cycles into LISTEN.
  - rx_sync high only during LISTEN; done next cycle with timeout=0.
  - stop and expiry in the same cycle → timeout=0.
- Overrun and abort:
  - trig during XMIT → trig_ovr pulse; timing of the running sequence unchanged.
  - abort at t=50 → all outputs 0 next cycle, no done; the following trig starts a fresh sequence at the next mode.
- Reset mid-sequence: rst=0 for one cycle during P3.
  - All outputs 0 on the next edge; the next trig selects mode 0.
